keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Sequences the 4x4 keypad matrix. Drives one-hot column strobes, synchronizes and debounces row returns, emits exactly one key event per physical press, and keeps a two-digit history (newest/previous) for the dual seven-segment display path. Sits between the keypad pins and two_ssd, clocked directly from the low-speed oscillator.

Parameters:
SCAN_DIV, 40, clock cycles each column stays driven while scanning (min 3, covers sync latency)
DEBOUNCE_CYCLES, 200, consecutive stable cycles required to accept a press or a release (20 ms at 10 kHz)

Ports:
clk  input  1  system clock (low-speed oscillator)
reset  input  1  asynchronous, active-low reset
rows  input  4  raw row returns, active-high, asynchronous to clk
cols  output  4  column drive, one-hot active-high
key_valid  output  1  one-cycle pulse on accepted press
key_code  output  4  hex code of last accepted key
key_held  output  1  high while accepted key is still down (incl. release debounce)
digit_new  output  4  most recent key code
digit_old  output  4  previous key code

Behaviour:
- Reset (async assert, sync release): state SCAN, cols=4'b0001, dwell/debounce counters 0, key_valid=0, key_held=0, key_code=0, digit_new=0, digit_old=0, sync flops 0.
- rows pass through a 2-flop synchronizer. The FSM sees only rows_s, with 2-cycle latency.
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN: dwell counter runs 0..SCAN_DIV-1. On the last dwell cycle, sample rows_s.
  - Exactly one bit set: latch row index and the current column index, hold cols, go to DEBOUNCE.
  - Zero or more than one bit set: rotate cols (0001->0010->0100->1000->0001) and stay in SCAN.
- DEBOUNCE: counter increments while the latched row bit stays high. If the bit drops, return to SCAN, advance cols, and emit no event.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the bit still high, all of the following happen in the same cycle:
  - key_valid=1 for exactly one cycle.
  - key_code, digit_new <= decoded code; digit_old <= previous digit_new.
  - key_held <= 1; go to HELD.
- HELD: cols frozen. Other rows are ignored (no rollover, no second event). When the latched row bit goes low, clear the counter and go to RELEASE.
- RELEASE: the row must stay low for DEBOUNCE_CYCLES consecutive cycles.
  - Any high sample returns to HELD with no new event.
  - On completion: key_held=0, go to SCAN, cols advance to the next column, dwell counter restarts at 0.
- Decode map (row,col -> code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Counter widths use $clog2 of the parameter. No counter wraps; every counter is cleared on each state entry.
- Pressing the same key repeatedly produces one event per press/release cycle, and the digit history shifts every time (digit_old may equal digit_new).
- Reset mid-debounce or mid-hold discards the pending key immediately, with no key_valid pulse.

Decomposition:
- Package keypad_pkg holds:
  - scan_state_t enum {SCAN, DEBOUNCE, HELD, RELEASE}
  - function key_map(row_idx, col_idx) returning logic [3:0]
  - constants NUM_ROWS=4, NUM_COLS=4
- Sub-module sync_2ff (parameterized width) for the rows synchronizer. Everything else stays in one FSM module.

Test Plan:
(All tests use SCAN_DIV=4, DEBOUNCE_CYCLES=8.)
1. Reset, rows=0 for 40 cycles -> cols cycles 0001,0010,0100,1000 every 4 cycles; key_valid never asserts; digits stay 0.
2. Assert rows[1] only while cols=0100 and hold for 30 cycles -> exactly one key_valid pulse, key_code=6, digit_new=6, digit_old=0, key_held=1, cols frozen at 0100.
3. Continue from test 2, then release for 10 cycles. Next, press row3/col1 the same way -> key_code=0, digit_new=0, digit_old=6, one pulse only.
4. Bounce: rows[0] with cols=0001 high 3 cycles, low 2, high 3, then low -> no key_valid; scanning resumes at cols=0010.
5. Two rows high together during a dwell (rows=0011) -> no latch, cols keep rotating. Release bounce (low 3 cycles, high 1) in HELD -> stays HELD, no second pulse.
6. Assert reset low mid-DEBOUNCE -> outputs return to reset values immediately. After release: no pulse, cols=0001, digits 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and the key decode table for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } scan_state_t;

  // Matrix position to hex legend as printed on the keypad.
  function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobing, press/release debounce, one event per press
// and a two-digit history for the seven-segment display path.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 40,
  parameter int DEBOUNCE_CYCLES = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int DW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  scan_state_t     r_state,     w_state;
  logic [DW_W-1:0] r_dwell,     w_dwell;
  logic [DB_W-1:0] r_db_cnt,    w_db_cnt;
  logic [1:0]      r_col_idx,   w_col_idx;
  logic [1:0]      r_row_idx,   w_row_idx;
  logic            r_key_valid, w_key_valid;
  logic [3:0]      r_key_code,  w_key_code;
  logic            r_key_held,  w_key_held;
  logic [3:0]      r_digit_new, w_digit_new;
  logic [3:0]      r_digit_old, w_digit_old;

  logic [3:0]      w_rows_s;
  logic            w_onehot;
  logic [1:0]      w_hot_idx;
  logic            w_row_hi;

  sync_2ff #(.WIDTH(NUM_ROWS)) u_rows_sync (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_d    (rows),
    .o_q    (w_rows_s)
  );

  always_comb begin
    w_hot_idx = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (w_rows_s[i]) w_hot_idx = 2'(i);
    end
  end

  assign w_onehot = $onehot(w_rows_s);
  assign w_row_hi = w_rows_s[r_row_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= SCAN;
      r_dwell     <= '0;
      r_db_cnt    <= '0;
      r_col_idx   <= '0;
      r_row_idx   <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_key_held  <= 1'b0;
      r_digit_new <= '0;
      r_digit_old <= '0;
    end else begin
      r_state     <= w_state;
      r_dwell     <= w_dwell;
      r_db_cnt    <= w_db_cnt;
      r_col_idx   <= w_col_idx;
      r_row_idx   <= w_row_idx;
      r_key_valid <= w_key_valid;
      r_key_code  <= w_key_code;
      r_key_held  <= w_key_held;
      r_digit_new <= w_digit_new;
      r_digit_old <= w_digit_old;
    end
  end

  // Only the latched row is watched once a key is captured; other rows are ignored.
  always_comb begin
    w_state     = r_state;
    w_dwell     = r_dwell;
    w_db_cnt    = r_db_cnt;
    w_col_idx   = r_col_idx;
    w_row_idx   = r_row_idx;
    w_key_valid = 1'b0;
    w_key_code  = r_key_code;
    w_key_held  = r_key_held;
    w_digit_new = r_digit_new;
    w_digit_old = r_digit_old;
    case (r_state)
      SCAN: begin
        if (r_dwell == DW_LAST) begin
          w_dwell = '0;
          if (w_onehot) begin
            w_row_idx = w_hot_idx;
            w_db_cnt  = '0;
            w_state   = DEBOUNCE;
          end else begin
            w_col_idx = r_col_idx + 2'd1;
          end
        end else begin
          w_dwell = r_dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!w_row_hi) begin
          w_state   = SCAN;
          w_col_idx = r_col_idx + 2'd1;
          w_dwell   = '0;
          w_db_cnt  = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_key_valid = 1'b1;
          w_key_code  = key_map(r_row_idx, r_col_idx);
          w_digit_new = key_map(r_row_idx, r_col_idx);
          w_digit_old = r_digit_new;
          w_key_held  = 1'b1;
          w_db_cnt    = '0;
          w_state     = HELD;
        end else begin
          w_db_cnt = r_db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!w_row_hi) begin
          w_db_cnt = '0;
          w_state  = RELEASE;
        end
      end
      RELEASE: begin
        if (w_row_hi) begin
          w_db_cnt = '0;
          w_state  = HELD;
        end else if (r_db_cnt == DB_LAST) begin
          w_key_held = 1'b0;
          w_db_cnt   = '0;
          w_dwell    = '0;
          w_col_idx  = r_col_idx + 2'd1;
          w_state    = SCAN;
        end else begin
          w_db_cnt = r_db_cnt + 1'b1;
        end
      end
      default: w_state = SCAN;
    endcase
  end

  assign cols      = 4'b0001 << r_col_idx;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_held  = r_key_held;
  assign digit_new = r_digit_new;
  assign digit_old = r_digit_old;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed and randomized bench for keypad_scan_ctrl, checked every cycle against
// a behavioural model of the scan/debounce protocol.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV        = 4;
  localparam int DEBOUNCE_CYCLES = 8;

  localparam int PH_SCANNING = 0;
  localparam int PH_PRESSING = 1;
  localparam int PH_DOWN     = 2;
  localparam int PH_LIFTING  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] rows = 4'b0000;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  int testsRun = 0;
  int failCount = 0;
  int validCount = 0;

  int         mCol, mDwell, mPhase, mRow, mRun;
  logic [3:0] mSync1, mSync2;
  int         expValid, expCode, expNew, expOld, expHeld;
  int         keyTable [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

  keypad_scan_ctrl #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held),
    .digit_new(digit_new),
    .digit_old(digit_old)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic initModel();
    mCol = 0; mDwell = 0; mPhase = PH_SCANNING; mRow = 0; mRun = 0;
    mSync1 = 4'b0000; mSync2 = 4'b0000;
    expValid = 0; expCode = 0; expNew = 0; expOld = 0; expHeld = 0;
  endtask

  task automatic modelStep();
    logic [3:0] sample;
    sample = mSync2;
    mSync2 = mSync1;
    mSync1 = rows;
    expValid = 0;
    case (mPhase)
      PH_SCANNING: begin
        mDwell++;
        if (mDwell == SCAN_DIV) begin
          mDwell = 0;
          if ($countones(sample) == 1) begin
            for (int i = 0; i < 4; i++) if (sample[i]) mRow = i;
            mRun = 0;
            mPhase = PH_PRESSING;
          end else begin
            mCol = (mCol + 1) % 4;
          end
        end
      end
      PH_PRESSING: begin
        if (sample[mRow]) begin
          mRun++;
          if (mRun == DEBOUNCE_CYCLES) begin
            expValid = 1;
            expCode = keyTable[mRow * 4 + mCol];
            expOld = expNew;
            expNew = expCode;
            expHeld = 1;
            mPhase = PH_DOWN;
          end
        end else begin
          mPhase = PH_SCANNING;
          mCol = (mCol + 1) % 4;
          mDwell = 0;
        end
      end
      PH_DOWN: begin
        if (!sample[mRow]) begin
          mPhase = PH_LIFTING;
          mRun = 0;
        end
      end
      PH_LIFTING: begin
        if (sample[mRow]) begin
          mPhase = PH_DOWN;
        end else begin
          mRun++;
          if (mRun == DEBOUNCE_CYCLES) begin
            expHeld = 0;
            mPhase = PH_SCANNING;
            mCol = (mCol + 1) % 4;
            mDwell = 0;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    logic [3:0] expCols;
    @(posedge clk);
    if (reset) modelStep();
    else initModel();
    #1;
    if (key_valid === 1'b1) validCount++;
    expCols = 4'(1 << mCol);
    checkOutput("cols", cols, expCols);
    checkOutput("key_valid", key_valid, expValid);
    checkOutput("key_code", key_code, expCode);
    checkOutput("key_held", key_held, expHeld);
    checkOutput("digit_new", digit_new, expNew);
    checkOutput("digit_old", digit_old, expOld);
  endtask

  task automatic applyStimulus(input logic [3:0] val, input int cycles);
    rows = val;
    repeat (cycles) tick();
  endtask

  task automatic waitForColumn(input int col);
    int n;
    n = 0;
    rows = 4'b0000;
    while (!(mPhase == PH_SCANNING && mCol == col && mDwell == 0) && n < 64) begin
      tick();
      n++;
    end
    checkOutput("waitColumnTimeout", (n >= 64), 0);
  endtask

  task automatic pressKey(input int row, input int col, input int hold);
    waitForColumn(col);
    applyStimulus(4'(1 << row), hold);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cols"}, cols, 4'b0001);
    checkOutput({tag, "_valid"}, key_valid, 0);
    checkOutput({tag, "_code"}, key_code, 0);
    checkOutput({tag, "_held"}, key_held, 0);
    checkOutput({tag, "_new"}, digit_new, 0);
    checkOutput({tag, "_old"}, digit_old, 0);
  endtask

  initial begin
    initModel();
    reset = 1'b0;
    rows = 4'b0000;
    #2;
    checkResetValues("reset0");
    tick();
    tick();
    reset = 1'b1;

    // Idle scanning: columns rotate, nothing is reported.
    validCount = 0;
    applyStimulus(4'b0000, 40);
    checkOutput("t1_pulses", validCount, 0);
    checkOutput("t1_digit_new", digit_new, 0);

    // Key 6 (row 1, column 2) pressed and held.
    validCount = 0;
    pressKey(1, 2, 30);
    checkOutput("t2_pulses", validCount, 1);
    checkOutput("t2_code", key_code, 4'h6);
    checkOutput("t2_new", digit_new, 4'h6);
    checkOutput("t2_old", digit_old, 4'h0);
    checkOutput("t2_held", key_held, 1);
    checkOutput("t2_cols", cols, 4'b0100);

    // Release, then key 0 (row 3, column 1): history shifts.
    applyStimulus(4'b0000, 10);
    validCount = 0;
    pressKey(3, 1, 30);
    checkOutput("t3_pulses", validCount, 1);
    checkOutput("t3_code", key_code, 4'h0);
    checkOutput("t3_new", digit_new, 4'h0);
    checkOutput("t3_old", digit_old, 4'h6);
    applyStimulus(4'b0000, 12);
    checkOutput("t3_released", key_held, 0);

    // Press bounce on row 0 produces no event.
    validCount = 0;
    waitForColumn(0);
    applyStimulus(4'b0001, 3);
    applyStimulus(4'b0000, 2);
    applyStimulus(4'b0001, 3);
    applyStimulus(4'b0000, 10);
    checkOutput("t4_pulses", validCount, 0);
    checkOutput("t4_held", key_held, 0);

    // Two rows at once never latch; release bounce keeps the key held.
    validCount = 0;
    waitForColumn(0);
    applyStimulus(4'b0011, 16);
    checkOutput("t5_multi_pulses", validCount, 0);
    checkOutput("t5_multi_held", key_held, 0);
    pressKey(2, 3, 20);
    applyStimulus(4'b0000, 3);
    applyStimulus(4'b0100, 1);
    applyStimulus(4'b0100, 10);
    checkOutput("t5_bounce_pulses", validCount, 1);
    checkOutput("t5_bounce_held", key_held, 1);
    checkOutput("t5_bounce_code", key_code, 4'hC);
    applyStimulus(4'b0000, 15);
    checkOutput("t5_released", key_held, 0);

    // Reset in the middle of a debounce discards the pending key.
    validCount = 0;
    waitForColumn(0);
    applyStimulus(4'b0001, 8);
    reset = 1'b0;
    rows = 4'b0000;
    #1;
    initModel();
    checkResetValues("t6_async");
    tick();
    tick();
    reset = 1'b1;
    applyStimulus(4'b0000, 3);
    checkOutput("t6_pulses", validCount, 0);
    checkOutput("t6_cols", cols, 4'b0001);
    checkOutput("t6_digit_new", digit_new, 0);
    checkOutput("t6_digit_old", digit_old, 0);

    // Randomized presses with noise and release bounce.
    for (int k = 0; k < 20; k++) begin
      int r, c;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      applyStimulus(4'($urandom_range(0, 15)), $urandom_range(0, 5));
      pressKey(r, c, $urandom_range(3, 25));
      applyStimulus(4'b0000, $urandom_range(1, 4));
      applyStimulus(4'(1 << r), $urandom_range(1, 3));
      applyStimulus(4'b0000, $urandom_range(5, 14));
    end
    applyStimulus(4'b0000, 20);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
